// File: rtl/mult_seq_ctrl_if.sv
// Request/response and shared-multiplier signals for mult_seq_ctrl.
// slave = sequencer side; master = requester plus the external N x N multiplier.
interface mult_seq_ctrl_if #(
  parameter int N = 4
);
  localparam int OP_W  = 2*N;
  localparam int RES_W = 4*N;

  logic             start;
  logic [OP_W-1:0]  op_a;
  logic [OP_W-1:0]  op_b;
  logic             ready;
  logic             done;
  logic [RES_W-1:0] result;
  logic [N-1:0]     mult_dataa;
  logic [N-1:0]     mult_datab;
  logic [2*N-1:0]   mult_product;

  modport slave (
    input  start, op_a, op_b, mult_product,
    output ready, done, result, mult_dataa, mult_datab
  );

  modport master (
    output start, op_a, op_b, mult_product,
    input  ready, done, result, mult_dataa, mult_datab
  );
endinterface

// File: rtl/mult_seq_ctrl.sv
// 2N x 2N multiply sequenced over four passes of one external N x N multiplier.
// Define MULT_SEQ_SIGNED_EN for two's-complement operands (sign-magnitude around the unsigned core).
module mult_seq_ctrl #(
  parameter int N = 4
) (
  input  logic          clk,
  input  logic          reset_n,
  mult_seq_ctrl_if.slave bus
);
  localparam int OP_W  = 2*N;
  localparam int RES_W = 4*N;

  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;

  state_t           state_q, state_d;
  logic [1:0]       step_q, step_d;
  logic [OP_W-1:0]  a_q, a_d, b_q, b_d;
  logic [RES_W-1:0] acc_q, acc_d, res_q, res_d;
  logic [N-1:0]     a_sl, b_sl;
  logic [RES_W-1:0] prod_ext, prod_sh, sum;

`ifdef MULT_SEQ_SIGNED_EN
  logic             neg_q, neg_d;
  logic [OP_W-1:0]  a_abs, b_abs;
  // -2^(OP_W-1) negates to itself, which read unsigned is the correct magnitude
  assign a_abs = bus.op_a[OP_W-1] ? -bus.op_a : bus.op_a;
  assign b_abs = bus.op_b[OP_W-1] ? -bus.op_b : bus.op_b;
`endif

  // step[0] picks the A half, step[1] the B half
  assign a_sl = step_q[0] ? a_q[OP_W-1:N] : a_q[N-1:0];
  assign b_sl = step_q[1] ? b_q[OP_W-1:N] : b_q[N-1:0];

  assign bus.mult_dataa = (state_q == CALC) ? a_sl : '0;
  assign bus.mult_datab = (state_q == CALC) ? b_sl : '0;
  assign bus.ready      = (state_q == IDLE);
  assign bus.done       = (state_q == DONE);
  assign bus.result     = res_q;

  always_comb begin
    prod_ext = {{(RES_W-2*N){1'b0}}, bus.mult_product};
    case (step_q)
      2'd0:    prod_sh = prod_ext;
      2'd3:    prod_sh = prod_ext << (2*N);
      default: prod_sh = prod_ext << N;
    endcase
    sum = (step_q == 2'd0) ? prod_ext : acc_q + prod_sh;
  end

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    res_d   = res_q;
`ifdef MULT_SEQ_SIGNED_EN
    neg_d   = neg_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.start) begin
`ifdef MULT_SEQ_SIGNED_EN
          a_d   = a_abs;
          b_d   = b_abs;
          neg_d = bus.op_a[OP_W-1] ^ bus.op_b[OP_W-1];
`else
          a_d   = bus.op_a;
          b_d   = bus.op_b;
`endif
          step_d  = 2'd0;
          state_d = CALC;
        end
      end
      CALC: begin
        acc_d  = sum;
        step_d = step_q + 2'd1;
        if (step_q == 2'd3) begin
          state_d = DONE;
`ifdef MULT_SEQ_SIGNED_EN
          res_d   = neg_q ? -sum : sum;
`else
          res_d   = sum;
`endif
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      step_q  <= 2'd0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      res_q   <= '0;
`ifdef MULT_SEQ_SIGNED_EN
      neg_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      res_q   <= res_d;
`ifdef MULT_SEQ_SIGNED_EN
      neg_q   <= neg_d;
`endif
    end
  end
endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Directed bench for mult_seq_ctrl with a behavioural 4x4 multiplier on the shared port.
// Expected values are hand-computed; signed vectors are selected by MULT_SEQ_SIGNED_EN.
module tb_mult_seq_ctrl;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   n_chk = 0;
  int   n_err = 0;

  mult_seq_ctrl_if #(.N(4)) bus();

  mult_seq_ctrl #(.N(4)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  assign bus.mult_product = bus.mult_dataa * bus.mult_datab;

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one op from IDLE, check 5-cycle latency and result, return to IDLE.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                        input logic [15:0] exp, input string tag);
    int n;
    chk({tag, "_rdy"}, {31'd0, bus.ready}, 32'd1);
    bus.op_a  = a;
    bus.op_b  = b;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    n = 1;
    while (!bus.done && n < 10) begin
      tick();
      n++;
    end
    chk({tag, "_lat"}, n, 5);
    chk({tag, "_res"}, {16'd0, bus.result}, {16'd0, exp});
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start = 1'b0;
    bus.op_a  = '0;
    bus.op_b  = '0;

    // reset state
    tick(); tick();
    chk("rst_ready", {31'd0, bus.ready}, 32'd1);
    chk("rst_done",  {31'd0, bus.done},  32'd0);
    chk("rst_res",   {16'd0, bus.result}, 32'd0);
    chk("rst_da",    {28'd0, bus.mult_dataa}, 32'd0);
    chk("rst_db",    {28'd0, bus.mult_datab}, 32'd0);
    #3 reset_n = 1'b1;
    tick();

    // 0F x 0F: per-step slice ordering and single done pulse
    bus.op_a = 8'h0F; bus.op_b = 8'h0F; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("s0_ab", {24'd0, bus.mult_dataa, bus.mult_datab}, 32'hFF);
    chk("s0_done", {31'd0, bus.done}, 32'd0);
    tick();
    chk("s1_ab", {24'd0, bus.mult_dataa, bus.mult_datab}, 32'h0F);
    tick();
    chk("s2_ab", {24'd0, bus.mult_dataa, bus.mult_datab}, 32'hF0);
    tick();
    chk("s3_ab", {24'd0, bus.mult_dataa, bus.mult_datab}, 32'h00);
    chk("s3_done", {31'd0, bus.done}, 32'd0);
    tick();
    chk("t5_done", {31'd0, bus.done}, 32'd1);
    chk("t5_res",  {16'd0, bus.result}, 32'h00E1);
    tick();
    chk("t6_done",  {31'd0, bus.done},  32'd0);
    chk("t6_ready", {31'd0, bus.ready}, 32'd1);
    chk("t6_hold",  {16'd0, bus.result}, 32'h00E1);

    run_op(8'hFF, 8'hFF, 16'hFE01, "ffff");
    run_op(8'h00, 8'hFF, 16'h0000, "zero");
    run_op(8'hA5, 8'h3C, 16'h26AC, "a53c");
    run_op(8'h10, 8'h01, 16'h0010, "hi_lo");

    // start held through CALC: later operands ignored until next IDLE
    bus.op_a = 8'd12; bus.op_b = 8'd10; bus.start = 1'b1;
    tick();
    bus.op_a = 8'd3; bus.op_b = 8'd3;
    chk("b2b_busy", {31'd0, bus.ready}, 32'd0);
    tick(); tick(); tick(); tick();
    chk("b2b_done1", {31'd0, bus.done}, 32'd1);
    chk("b2b_res1",  {16'd0, bus.result}, 32'd120);
    tick();
    chk("b2b_rdy6", {31'd0, bus.ready}, 32'd1);
    tick();
    chk("b2b_acc7", {31'd0, bus.ready}, 32'd0);
    chk("b2b_hold", {16'd0, bus.result}, 32'd120);
    bus.start = 1'b0;
    tick(); tick(); tick();
    chk("b2b_nodone", {31'd0, bus.done}, 32'd0);
    tick();
    chk("b2b_done2", {31'd0, bus.done}, 32'd1);
    chk("b2b_res2",  {16'd0, bus.result}, 32'd9);
    tick();

    // reset during step 2 aborts
    bus.op_a = 8'd200; bus.op_b = 8'd2; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick(); tick();
    chk("ab_s2", {24'd0, bus.mult_dataa, bus.mult_datab}, 32'h80);
    reset_n = 1'b0;
    #1;
    chk("ab_res",   {16'd0, bus.result}, 32'd0);
    chk("ab_ready", {31'd0, bus.ready},  32'd1);
    chk("ab_da",    {28'd0, bus.mult_dataa}, 32'd0);
    tick(); tick(); tick();
    chk("ab_nodone", {31'd0, bus.done}, 32'd0);
    #3 reset_n = 1'b1;
    tick();
    run_op(8'd7, 8'd6, 16'd42, "post_rst");

`ifdef MULT_SEQ_SIGNED_EN
    run_op(8'hFD, 8'h05, 16'hFFF1, "sgn_neg");
    run_op(8'h80, 8'h80, 16'h4000, "sgn_min");
    run_op(8'hFD, 8'hFB, 16'h000F, "sgn_nn");
`else
    run_op(8'hFD, 8'h05, 16'h04F1, "uns_fd05");
    run_op(8'h80, 8'h80, 16'h4000, "uns_8080");
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
